// File: rtl/note_fetch_buffer_pkg.sv
// Shared definitions for the note prefetch path: chart word layout, the
// end-of-chart marker and the fetch FSM state encoding.
package note_fetch_buffer_pkg;

    localparam int TIME_W = 16;

    // "No note" value; a chart word carrying it terminates the chart.
    localparam logic [TIME_W-1:0] END_MARKER = 16'hFFFF;

    // Song memory word layout: {lane_mask, time_10ms}; time unit is 10 ms.
    localparam int TIME_LSB = 0;
    localparam int MASK_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_END   = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/note_fetch_buffer_note_fifo.sv
// Synchronous show-ahead FIFO holding note times for one lane.
// DEPTH must be a power of two so the pointers wrap naturally.
module note_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // The upstream credit scheme must never push into a full FIFO.
    push_into_full: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop && !flush));

endmodule

// File: rtl/note_fetch_buffer.sv
// Per-lane chart prefetch: streams song memory after start, keeps this lane's
// notes in a small FIFO and serves one note time per matcher request.
module note_fetch_buffer
    import note_fetch_buffer_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int MEM_LAT    = 2,
    parameter int NUM_LANES  = 5,
    parameter int LANE       = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        mem_rd_en,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [TIME_W+NUM_LANES-1:0] mem_data,
    input  logic                        note_request,
    output logic                        note_available,
    output logic [TIME_W-1:0]           note_time,
    output logic                        song_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MEM_LAT + 1);
    localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [MEM_LAT-1:0]  valid_q, valid_d;
    logic                end_seen_q, end_seen_d;
    logic                wrap_q, wrap_d;
    logic                avail_q, avail_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic                done_q, done_d;

    logic                fifo_push, fifo_pop, fifo_flush;
    logic [TIME_W-1:0]   fifo_dout;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty, fifo_full;

    logic [OUT_W-1:0]    outstanding;
    logic                can_issue, mem_issue;
    logic                ret_valid, ret_lane, ret_marker;
    logic [TIME_W-1:0]   ret_time;
    logic                serve_req;
    logic                unused_bits;

    note_fifo #(
        .WIDTH (TIME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (ret_time),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < MEM_LAT; i++) outstanding += OUT_W'(valid_q[i]);
    end

    // Credit: reads in flight plus buffered notes may never exceed the FIFO depth.
    assign can_issue  = (SUM_W'(fifo_count) + SUM_W'(outstanding)) < SUM_W'(FIFO_DEPTH);
    assign ret_valid  = valid_q[MEM_LAT-1];
    assign ret_time   = mem_data[TIME_LSB +: TIME_W];
    assign ret_lane   = mem_data[MASK_LSB + LANE];
    assign ret_marker = ret_valid && (ret_time == END_MARKER);
    // The !avail_q gate stops a second pop on the cycle the matcher drops its request.
    assign serve_req  = note_request && !avail_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        end_seen_d = end_seen_q;
        wrap_d     = wrap_q;
        avail_d    = 1'b0;
        time_d     = time_q;
        done_d     = end_seen_q && fifo_empty && (outstanding == '0);
        mem_issue  = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        if (start) begin
            fifo_flush = 1'b1;
            valid_d    = '0;
            addr_d     = '0;
            end_seen_d = 1'b0;
            wrap_d     = 1'b0;
            done_d     = 1'b0;
            state_d    = ST_FETCH;
        end else begin
            if (serve_req) begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    avail_d  = 1'b1;
                    time_d   = fifo_dout;
                end else if (end_seen_q && (outstanding == '0)) begin
                    avail_d  = 1'b1;
                    time_d   = END_MARKER;
                end
            end

            case (state_q)
                ST_FETCH: begin
                    mem_issue  = !wrap_q && !ret_marker && can_issue;
                    valid_d[0] = mem_issue;
                    for (int i = 1; i < MEM_LAT; i++) valid_d[i] = valid_q[i-1];
                    if (mem_issue) begin
                        // The last address is issued once and never wrapped back to 0.
                        if (addr_q == ADDR_LAST) wrap_d = 1'b1;
                        else                     addr_d = addr_q + 1'b1;
                    end
                    if (ret_marker) begin
                        end_seen_d = 1'b1;
                        valid_d    = '0;
                        state_d    = ST_END;
                    end else if (ret_valid && ret_lane) begin
                        fifo_push  = 1'b1;
                    end else if (wrap_q && (valid_q == '0)) begin
                        end_seen_d = 1'b1;
                        state_d    = ST_END;
                    end
                end
                default: valid_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            valid_q    <= '0;
            end_seen_q <= 1'b0;
            wrap_q     <= 1'b0;
            avail_q    <= 1'b0;
            time_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            end_seen_q <= end_seen_d;
            wrap_q     <= wrap_d;
            avail_q    <= avail_d;
            time_q     <= time_d;
            done_q     <= done_d;
        end
    end

    assign mem_rd_en      = mem_issue;
    assign mem_addr       = addr_q;
    assign note_available = avail_q;
    assign note_time      = time_q;
    assign song_done      = done_q;

    // Other lanes' mask bits and the full flag are intentionally not consumed.
    assign unused_bits = ^{mem_data, fifo_full};

endmodule

// File: tb/tb_note_fetch_buffer.sv
// Self-checking bench for note_fetch_buffer: song memory model, matcher-style
// requester and an expected-note scoreboard per instance.
module tb_note_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, req_a = 1'b0;
    logic        start_b = 1'b0, req_b = 1'b0;
    logic        rd_en_a, rd_en_b;
    logic [11:0] addr_a;
    logic [2:0]  addr_b;
    logic [20:0] data_a, data_b;
    logic        avail_a, avail_b, done_a, done_b;
    logic [15:0] time_a, time_b;

    logic [20:0] mem_a [64];
    logic [20:0] mem_b [8];
    logic [20:0] pa1 = '0, pa2 = '0, pb1 = '0, pb2 = '0;

    logic [15:0] sb_a [$];
    logic [15:0] sb_b [$];
    int n_checks = 0;
    int n_errors = 0;
    int pulses_a = 0, pulses_b = 0;
    int rd_cnt_a = 0, rd_cnt_b = 0;
    int max_cnt_a = 0;
    logic rd_at_pulse_a = 1'b0;

    always #5 clk = ~clk;

    note_fetch_buffer #(.ADDR_W(12), .MEM_LAT(2), .NUM_LANES(5), .LANE(0), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mem_rd_en(rd_en_a), .mem_addr(addr_a),
        .mem_data(data_a), .note_request(req_a), .note_available(avail_a),
        .note_time(time_a), .song_done(done_a)
    );

    note_fetch_buffer #(.ADDR_W(3), .MEM_LAT(2), .NUM_LANES(5), .LANE(0), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mem_rd_en(rd_en_b), .mem_addr(addr_b),
        .mem_data(data_b), .note_request(req_b), .note_available(avail_b),
        .note_time(time_b), .song_done(done_b)
    );

    function automatic logic [20:0] word(input logic [4:0] mask, input logic [15:0] t);
        return {mask, t};
    endfunction

    // Song memory: data is valid two cycles after the read strobe.
    always @(posedge clk) begin
        pa1 <= rd_en_a ? ((addr_a < 12'd64) ? mem_a[addr_a[5:0]] : word(5'b0, 16'hFFFF)) : '0;
        pa2 <= pa1;
        pb1 <= rd_en_b ? mem_b[addr_b] : '0;
        pb2 <= pb1;
        if (rd_en_a) rd_cnt_a++;
        if (rd_en_b) rd_cnt_b++;
    end
    assign data_a = pa2;
    assign data_b = pb2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (int'(dut_a.u_fifo.count) > max_cnt_a) max_cnt_a = int'(dut_a.u_fifo.count);
        if (avail_a) begin
            pulses_a++;
            rd_at_pulse_a = rd_en_a;
            if (sb_a.size() == 0) check("spurious_pulse_a", {31'b0, avail_a}, 32'd0);
            else                  check("note_a", {16'b0, time_a}, {16'b0, sb_a.pop_front()});
        end
        if (avail_b) begin
            pulses_b++;
            if (sb_b.size() == 0) check("spurious_pulse_b", {31'b0, avail_b}, 32'd0);
            else                  check("note_b", {16'b0, time_b}, {16'b0, sb_b.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int which);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        tick(1);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Wait (bounded) for a pulse, then drop the request after the overlap edge.
    task automatic wait_pulse(input int which);
        int   budget = 60;
        logic got = 1'b0;
        while (!got && budget > 0) begin
            @(negedge clk);
            got = (which == 0) ? avail_a : avail_b;
            budget--;
        end
        if (!got) begin
            check("request_timeout", 32'd0, 32'd1);
            if (which == 0 && sb_a.size() > 0) void'(sb_a.pop_back());
            if (which == 1 && sb_b.size() > 0) void'(sb_b.pop_back());
        end
        @(posedge clk);
        #1;
        if (which == 0) req_a = 1'b0; else req_b = 1'b0;
    endtask

    task automatic serve(input int which, input logic [15:0] exp);
        if (which == 0) begin sb_a.push_back(exp); req_a = 1'b1; end
        else            begin sb_b.push_back(exp); req_b = 1'b1; end
        wait_pulse(which);
    endtask

    task automatic load_chart1(input logic [15:0] t1, input logic [4:0] m1);
        mem_a[0] = word(5'b00001, 16'd50);
        mem_a[1] = word(m1, t1);
        mem_a[2] = word(5'b00001, 16'd200);
        mem_a[3] = word(5'b00000, 16'hFFFF);
    endtask

    task automatic load_ten();
        for (int i = 0; i < 10; i++)
            mem_a[i] = word((i % 2 == 1) ? 5'b00101 : 5'b00001, 16'(10 * (i + 1)));
        mem_a[10] = word(5'b00000, 16'hFFFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int snap;
        for (int i = 0; i < 64; i++) mem_a[i] = word(5'b0, 16'hFFFF);
        for (int i = 0; i < 8; i++)
            mem_b[i] = word((i % 2 == 1) ? 5'b10001 : 5'b00001, 16'(300 + i));
        load_chart1(16'd120, 5'b00010);

        // Reset state
        tick(3);
        check("rst_avail", {31'b0, avail_a}, 32'd0);
        check("rst_time", {16'b0, time_a}, 32'd0);
        check("rst_rd_en", {31'b0, rd_en_a}, 32'd0);
        check("rst_addr", {20'b0, addr_a}, 32'd0);
        check("rst_done", {31'b0, done_a}, 32'd0);
        reset = 1'b0;
        tick(1);

        // Basic chart: lane-1 note filtered out, then end marker
        pulse_start(0);
        tick(12);
        check("t1_done_early", {31'b0, done_a}, 32'd0);
        check("t1_fifo_count", 32'(dut_a.u_fifo.count), 32'd2);
        serve(0, 16'd50);
        serve(0, 16'd200);
        serve(0, 16'hFFFF);
        tick(2);
        check("t1_song_done", {31'b0, done_a}, 32'd1);
        serve(0, 16'hFFFF);
        tick(5);
        check("t2_pulse_count", 32'(pulses_a), 32'd4);

        // Credit back-pressure with no requests
        load_ten();
        max_cnt_a = 0;
        base = rd_cnt_a;
        pulse_start(0);
        tick(20);
        check("t3_reads_issued", 32'(rd_cnt_a - base), 32'd4);
        check("t3_addr", {20'b0, addr_a}, 32'd4);
        check("t3_rd_stalled", {31'b0, rd_en_a}, 32'd0);
        check("t3_fifo_max", 32'(max_cnt_a), 32'd4);
        serve(0, 16'd10);
        check("t3_read_resume", {31'b0, rd_at_pulse_a}, 32'd1);
        for (int i = 1; i < 10; i++) serve(0, 16'(10 * (i + 1)));
        serve(0, 16'hFFFF);
        check("t3_fifo_max_after", 32'(max_cnt_a), 32'd4);

        // Restart with two reads in flight
        load_chart1(16'd77, 5'b00001);
        pulse_start(0);
        tick(2);
        pulse_start(0);
        check("t4_fifo_flushed", {31'b0, dut_a.u_fifo.empty}, 32'd1);
        tick(1);
        check("t4_late_ignored", {31'b0, dut_a.u_fifo.empty}, 32'd1);
        serve(0, 16'd50);
        serve(0, 16'd77);
        serve(0, 16'd200);
        serve(0, 16'hFFFF);

        // Address wrap acts as an implicit end marker
        base = rd_cnt_b;
        pulse_start(1);
        for (int i = 0; i < 8; i++) serve(1, 16'(300 + i));
        serve(1, 16'hFFFF);
        check("t5_reads_issued", 32'(rd_cnt_b - base), 32'd8);
        tick(2);
        check("t5_song_done", {31'b0, done_b}, 32'd1);
        check("t5_pulse_count", 32'(pulses_b), 32'd9);

        // Reset mid-stream with a request pending
        load_ten();
        pulse_start(0);
        tick(8);
        reset = 1'b1;
        req_a = 1'b1;
        tick(1);
        check("t6_avail", {31'b0, avail_a}, 32'd0);
        check("t6_time", {16'b0, time_a}, 32'd0);
        check("t6_rd_en", {31'b0, rd_en_a}, 32'd0);
        check("t6_addr", {20'b0, addr_a}, 32'd0);
        check("t6_done", {31'b0, done_a}, 32'd0);
        reset = 1'b0;
        snap = pulses_a;
        tick(8);
        check("t6_no_pulse_idle", 32'(pulses_a - snap), 32'd0);
        check("t6_idle_no_read", {31'b0, rd_en_a}, 32'd0);
        sb_a.push_back(16'd10);
        pulse_start(0);
        wait_pulse(0);
        tick(3);
        check("sb_a_drained", 32'(sb_a.size()), 32'd0);
        check("sb_b_drained", 32'(sb_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
